// File: rtl/inidata_pkg.sv
// Shared definitions for the stencil-buffer sequencer.
//   CNT_W     : width of the buffer address counters and the point count
//   PARK_ADDR : slot wr_cnt parks on whenever no record is being written
//   MIN_PTS   : smallest legal point count (a centre plus two neighbours each side)
//   FIRST_PT / LAST_OFS : sweep range, rd_cnt runs FIRST_PT .. N-LAST_OFS
//   state_t   : controller FSM states
// Optional feature macro: INIDATA_SEQ_BOUNDARY_EN (full 0..N-1 sweep).
package inidata_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] PARK_ADDR = CNT_W'(255);
  localparam int MIN_PTS = 5;

`ifdef INIDATA_SEQ_BOUNDARY_EN
  localparam logic [CNT_W-1:0] FIRST_PT = CNT_W'(0);
  localparam logic [CNT_W-1:0] LAST_OFS = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] FIRST_PT = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAST_OFS = CNT_W'(3);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // The upper bound is checked in int so it stays meaningful if CNT_W grows
  // past PARK_ADDR's range.
  function automatic logic legal_n(input logic [CNT_W-1:0] n);
    int nv;
    nv = int'(n);
    return (nv >= MIN_PTS) && (nv <= int'(PARK_ADDR));
  endfunction

endpackage

// File: rtl/inidata_seq_ctrl_if.sv
// Handshake / address bundle between the sequencer and its environment
// (record source, stencil buffer, calculation pipeline).
//   master : the sequencer (drives in_ready, addresses, cal_valid, status)
//   slave  : the environment (drives start, num_pts, in_valid, cal_ready)
// Optional feature macro: INIDATA_SEQ_BOUNDARY_EN adds edge_mask.
interface inidata_seq_ctrl_if;
  import inidata_pkg::*;

  logic             start;
  logic [CNT_W-1:0] num_pts;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             cal_valid;
  logic             cal_ready;
  logic             busy;
  logic             done;
  logic             err;
`ifdef INIDATA_SEQ_BOUNDARY_EN
  logic [3:0]       edge_mask;
`endif

  modport master (
    input  start, num_pts, in_valid, cal_ready,
`ifdef INIDATA_SEQ_BOUNDARY_EN
    output edge_mask,
`endif
    output in_ready, wr_cnt, rd_cnt, cal_valid, busy, done, err
  );

  modport slave (
    output start, num_pts, in_valid, cal_ready,
`ifdef INIDATA_SEQ_BOUNDARY_EN
    input  edge_mask,
`endif
    input  in_ready, wr_cnt, rd_cnt, cal_valid, busy, done, err
  );

endinterface

// File: rtl/inidata_addr_cnt.sv
// Loadable, enable-incrementing address counter.
//   clk, rst : clock, asynchronous active-high reset (cnt -> RST_VAL)
//   load     : cnt <= load_val (has priority over inc)
//   inc      : cnt <= cnt + 1
//   cnt      : current address
module inidata_addr_cnt #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (inc)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/inidata_seq_ctrl.sv
// Sequencer for the 6-field stencil buffer (r/alpha/K/phi/pi_m/psi).
// Loads N records from the input stream into buffer slots 0..N-1 via wr_cnt,
// waits one cycle for the last write, then sweeps rd_cnt over the points and
// hands each one to the calculation pipeline with a valid/ready handshake.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus.start       : start pulse, sampled in IDLE; bus.num_pts latched then
//   bus.in_valid/in_ready   : record stream handshake (data goes to the buffer)
//   bus.wr_cnt / bus.rd_cnt : buffer write / read (centre point) address
//   bus.cal_valid/cal_ready : calc pipeline handshake
//   bus.busy, bus.done, bus.err : status; done and err are one-cycle pulses
//   bus.edge_mask   : {i-2, i-1, i+1, i+2 invalid}, boundary build only
// Optional feature macro: INIDATA_SEQ_BOUNDARY_EN sweeps 0..N-1 and adds edge_mask.
module inidata_seq_ctrl
  import inidata_pkg::*;
(
  input logic                clk,
  input logic                rst,
  inidata_seq_ctrl_if.master bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [CNT_W-1:0] wr_last, rd_last;
  logic             err_q;
  logic             start_ok, start_bad;
  logic             wr_acc, wr_fin, rd_acc, rd_fin;

  assign start_ok  = (state == IDLE) && bus.start &&  legal_n(bus.num_pts);
  assign start_bad = (state == IDLE) && bus.start && !legal_n(bus.num_pts);
  assign wr_acc    = (state == LOAD) && bus.in_valid;
  assign wr_fin    = wr_acc && (wr_cnt == wr_last);
  assign rd_acc    = (state == RUN) && bus.cal_ready;
  assign rd_fin    = rd_acc && (rd_cnt == rd_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = LOAD;
      LOAD:    if (wr_fin)   state_nxt = SETTLE;
      SETTLE:                state_nxt = RUN;
      RUN:     if (rd_fin)   state_nxt = DONE;
      DONE:                  state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.cal_valid = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state)
      IDLE:    bus.busy      = 1'b0;
      LOAD:    bus.in_ready  = 1'b1;
      RUN:     bus.cal_valid = 1'b1;
      DONE:    bus.done      = 1'b1;
      default: ;
    endcase
  end

  // End points are fixed at latch time so the compares above never see a
  // subtraction that could wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_last <= '0;
      rd_last <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= start_bad;
      if (start_ok) begin
        wr_last <= bus.num_pts - CNT_W'(1);
        rd_last <= bus.num_pts - LAST_OFS;
      end
    end
  end

  // Write address: 0 on start, parks again as soon as the last record lands.
  inidata_addr_cnt #(.W(CNT_W), .RST_VAL(PARK_ADDR)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok || wr_fin),
    .load_val (wr_fin ? PARK_ADDR : '0),
    .inc      (wr_acc),
    .cnt      (wr_cnt)
  );

  // Read address: preset while entering SETTLE; the final handshake does not
  // advance it, so it holds the last point through DONE and never reaches PARK_ADDR.
  inidata_addr_cnt #(.W(CNT_W), .RST_VAL('0)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (wr_fin),
    .load_val (FIRST_PT),
    .inc      (rd_acc && !rd_fin),
    .cnt      (rd_cnt)
  );

  assign bus.wr_cnt = wr_cnt;
  assign bus.rd_cnt = rd_cnt;
  assign bus.err    = err_q;

`ifdef INIDATA_SEQ_BOUNDARY_EN
  // rd_last is N-1 here, so i+1 is out of range at rd_last and i+2 from rd_last-1.
  assign bus.edge_mask = {(rd_cnt < CNT_W'(2)),
                          (rd_cnt == '0),
                          (rd_cnt >= rd_last),
                          (rd_cnt >= rd_last - CNT_W'(1))};
`endif

endmodule

// File: tb/tb_inidata_seq_ctrl.sv
// Directed testbench for inidata_seq_ctrl (default and INIDATA_SEQ_BOUNDARY_EN builds).
module tb_inidata_seq_ctrl;

`ifdef INIDATA_SEQ_BOUNDARY_EN
  localparam int FIRST = 0;
  localparam int TAIL  = 1;
`else
  localparam int FIRST = 2;
  localparam int TAIL  = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   xfer_rd[$];
  int   xfer_em[$];
  bit   done_seen;

  inidata_seq_ctrl_if bus();

  inidata_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {in_ready, wr_cnt, rd_cnt, cal_valid, busy, done, err}
  localparam logic [20:0] RST_VEC = {1'b0, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

  function automatic logic [20:0] outs();
    return {bus.in_ready, bus.wr_cnt, bus.rd_cnt, bus.cal_valid, bus.busy, bus.done, bus.err};
  endfunction

  task automatic do_start(input int n);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_pts = 8'(n);
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  // Free-running load and sweep; records the rd_cnt of every transfer.
  task automatic sweep(input int n);
    bus.in_valid  = 1'b1;
    bus.cal_ready = 1'b1;
    xfer_rd.delete();
    xfer_em.delete();
    done_seen = 1'b0;
    do_start(n);
    for (int c = 0; c < 700 && !done_seen; c++) begin
      if (bus.cal_valid && bus.cal_ready) begin
        xfer_rd.push_back(int'(bus.rd_cnt));
`ifdef INIDATA_SEQ_BOUNDARY_EN
        xfer_em.push_back(int'(bus.edge_mask));
`endif
      end
      if (bus.done) done_seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++; $display("FAIL reset_vals got %h want %h", outs(), RST_VEC);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++; $display("FAIL idle_after_reset got %h want %h", outs(), RST_VEC);
    end
  endtask

  task automatic test_n8_stream();
    bus.in_valid  = 1'b1;
    bus.cal_ready = 1'b1;
    do_start(8);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if ({bus.in_ready, bus.busy, bus.wr_cnt} !== {1'b1, 1'b1, 8'(k)}) begin
        n_bad++; $display("FAIL n8_load k=%0d got rdy=%b wr=%0d want rdy=1 wr=%0d", k, bus.in_ready, bus.wr_cnt, k);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({bus.in_ready, bus.cal_valid, bus.busy, bus.wr_cnt, bus.rd_cnt} !== {1'b0, 1'b0, 1'b1, 8'd255, 8'(FIRST)}) begin
      n_bad++; $display("FAIL n8_settle got rdy=%b cv=%b busy=%b wr=%0d rd=%0d want 0 0 1 255 %0d",
                        bus.in_ready, bus.cal_valid, bus.busy, bus.wr_cnt, bus.rd_cnt, FIRST);
    end
    @(negedge clk);
    for (int i = FIRST; i <= 8 - TAIL; i++) begin
      n_cmp++;
      if ({bus.cal_valid, bus.done, bus.rd_cnt, bus.wr_cnt} !== {1'b1, 1'b0, 8'(i), 8'd255}) begin
        n_bad++; $display("FAIL n8_run i=%0d got cv=%b done=%b rd=%0d wr=%0d", i, bus.cal_valid, bus.done, bus.rd_cnt, bus.wr_cnt);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({bus.done, bus.cal_valid, bus.busy, bus.rd_cnt} !== {1'b1, 1'b0, 1'b1, 8'(8 - TAIL)}) begin
      n_bad++; $display("FAIL n8_done got done=%b cv=%b busy=%b rd=%0d want 1 0 1 %0d",
                        bus.done, bus.cal_valid, bus.busy, bus.rd_cnt, 8 - TAIL);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.wr_cnt} !== {1'b0, 1'b0, 8'd255}) begin
      n_bad++; $display("FAIL n8_idle got done=%b busy=%b wr=%0d want 0 0 255", bus.done, bus.busy, bus.wr_cnt);
    end
  endtask

  task automatic test_toggle();
    int exp_wr = 0;
    int acc    = 0;
    bus.in_valid  = 1'b0;
    bus.cal_ready = 1'b1;
    do_start(8);
    for (int c = 0; c < 40 && acc < 8; c++) begin
      n_cmp++;
      if ({bus.in_ready, bus.wr_cnt} !== {1'b1, 8'(exp_wr)}) begin
        n_bad++; $display("FAIL toggle_wr c=%0d got rdy=%b wr=%0d want rdy=1 wr=%0d", c, bus.in_ready, bus.wr_cnt, exp_wr);
      end
      bus.in_valid = (c % 2 == 0);
      if (bus.in_valid) begin
        acc++;
        exp_wr++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.in_ready, bus.wr_cnt, bus.rd_cnt} !== {1'b0, 8'd255, 8'(FIRST)}) begin
      n_bad++; $display("FAIL toggle_settle got rdy=%b wr=%0d rd=%0d want 0 255 %0d", bus.in_ready, bus.wr_cnt, bus.rd_cnt, FIRST);
    end
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (bus.done) done_seen = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (done_seen !== 1'b1) begin
      n_bad++; $display("FAIL toggle_done got %b want 1", done_seen);
    end
  endtask

  task automatic test_stall();
    bit seen_cv = 1'b0;
    int xfers   = 0;
    bus.in_valid  = 1'b1;
    bus.cal_ready = 1'b0;
    do_start(6);
    for (int c = 0; c < 20 && !seen_cv; c++) begin
      if (bus.cal_valid) seen_cv = 1'b1;
      else @(negedge clk);
    end
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if ({bus.cal_valid, bus.rd_cnt} !== {1'b1, 8'(FIRST)}) begin
        n_bad++; $display("FAIL stall_hold s=%0d got cv=%b rd=%0d want 1 %0d", s, bus.cal_valid, bus.rd_cnt, FIRST);
      end
      @(negedge clk);
    end
    bus.cal_ready = 1'b1;
    done_seen = 1'b0;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (bus.done) done_seen = 1'b1;
      else begin
        if (bus.cal_valid) begin
          n_cmp++;
          if (bus.rd_cnt !== 8'(FIRST + xfers)) begin
            n_bad++; $display("FAIL stall_seq got rd=%0d want %0d", bus.rd_cnt, FIRST + xfers);
          end
          xfers++;
        end
        @(negedge clk);
      end
    end
    n_cmp++;
    if (xfers !== 6 - 2 * FIRST || done_seen !== 1'b1) begin
      n_bad++; $display("FAIL stall_count got xfers=%0d done=%b want %0d 1", xfers, done_seen, 6 - 2 * FIRST);
    end
  endtask

  task automatic test_err();
    int bad_n[2] = '{4, 0};
    bus.cal_ready = 1'b1;
    foreach (bad_n[j]) begin
      do_start(bad_n[j]);
      n_cmp++;
      if ({bus.err, bus.busy, bus.in_ready} !== 3'b100) begin
        n_bad++; $display("FAIL err_pulse n=%0d got err=%b busy=%b rdy=%b want 1 0 0", bad_n[j], bus.err, bus.busy, bus.in_ready);
      end
      @(negedge clk);
      n_cmp++;
      if ({bus.err, bus.busy} !== 2'b00) begin
        n_bad++; $display("FAIL err_clear n=%0d got err=%b busy=%b want 0 0", bad_n[j], bus.err, bus.busy);
      end
    end
    sweep(5);
    n_cmp++;
    if (done_seen !== 1'b1 || xfer_rd.size() !== 5 - 2 * FIRST) begin
      n_bad++; $display("FAIL n5_count got done=%b xfers=%0d want 1 %0d", done_seen, xfer_rd.size(), 5 - 2 * FIRST);
    end
    else begin
      n_cmp++;
      if (xfer_rd[0] !== FIRST) begin
        n_bad++; $display("FAIL n5_first got rd=%0d want %0d", xfer_rd[0], FIRST);
      end
    end
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_bad++; $display("FAIL n5_err got %b want 0", bus.err);
    end
  endtask

`ifdef INIDATA_SEQ_BOUNDARY_EN
  task automatic test_edge_mask();
    int exp_em[5] = '{4'b1100, 4'b1000, 4'b0000, 4'b0001, 4'b0011};
    sweep(5);
    n_cmp++;
    if (xfer_em.size() !== 5) begin
      n_bad++; $display("FAIL em_count got %0d want 5", xfer_em.size());
    end
    else begin
      foreach (exp_em[i]) begin
        n_cmp++;
        if (xfer_rd[i] !== i || xfer_em[i] !== exp_em[i]) begin
          n_bad++; $display("FAIL em_i%0d got rd=%0d mask=%b want rd=%0d mask=%b", i, xfer_rd[i], 4'(xfer_em[i]), i, 4'(exp_em[i]));
        end
      end
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit seen_cv = 1'b0;
    bus.in_valid  = 1'b1;
    bus.cal_ready = 1'b0;
    do_start(8);
    for (int c = 0; c < 20 && !seen_cv; c++) begin
      if (bus.cal_valid) seen_cv = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if ({seen_cv, bus.busy} !== 2'b11) begin
      n_bad++; $display("FAIL mid_in_run got cv_seen=%b busy=%b want 1 1", seen_cv, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++; $display("FAIL mid_reset_async got %h want %h", outs(), RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++; $display("FAIL mid_reset_idle got %h want %h", outs(), RST_VEC);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.num_pts   = '0;
    bus.in_valid  = 1'b0;
    bus.cal_ready = 1'b0;
    test_reset();
    test_n8_stream();
    test_toggle();
    test_stall();
    test_err();
`ifdef INIDATA_SEQ_BOUNDARY_EN
    test_edge_mask();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
